// File: rtl/bsg_tag_tx_pkg.sv
// bsg_tag_tx_pkg
//   Shared definitions for the serial bsg_tag transmitter:
//   - bsg_tag_tx_state_e : FSM states, one per field of the serial frame
//   - DECLARE_BSG_TAG_TX_CMD_S(lg_els, lg_width) : macro that declares the
//     bsg_tag_tx_cmd_s command struct for a given node-ID / length width.
//     A package cannot take parameters, so the struct is stamped out by the
//     user module with its own parameter values.
//   - max4() : elaboration-time helper for sizing the shared down-counter
`ifndef BSG_TAG_TX_PKG_SV
`define BSG_TAG_TX_PKG_SV

`define DECLARE_BSG_TAG_TX_CMD_S(lg_els_mp, lg_width_mp) \
  typedef struct packed { \
    logic                          master_reset; \
    logic [lg_els_mp-1:0]          node_id; \
    logic                          data_not_reset; \
    logic [lg_width_mp-1:0]        len; \
    logic [(1<<lg_width_mp)-2:0]   payload; \
  } bsg_tag_tx_cmd_s

package bsg_tag_tx_pkg;

  typedef enum logic [2:0] {
    e_idle    = 3'd0,
    e_mrst    = 3'd1,
    e_start   = 3'd2,
    e_len     = 3'd3,
    e_dnr     = 3'd4,
    e_node    = 3'd5,
    e_payload = 3'd6,
    e_gap     = 3'd7
  } bsg_tag_tx_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

`endif

// File: rtl/bsg_tag_tx_shifter.sv
// bsg_tag_tx_shifter
//   Field shift register plus the shared per-state down-counter.
//   Ports:
//     clk_i, reset_n_i : clock, synchronous active-low reset
//     load_i           : load load_data_i / load_count_i (wins over shift_i)
//     load_data_i      : new field, bit 0 is the next bit on the wire
//     load_count_i     : cycles the field lasts, minus one
//     shift_i          : advance one bit and decrement the counter
//     fill_i           : bit shifted in at the top on each advance
//     bit_o            : current serial bit (straight from a flop)
//     count_o          : remaining cycles after this one
//     last_o           : this is the final cycle of the current field
module bsg_tag_tx_shifter
  import bsg_tag_tx_pkg::*;
#(
  parameter int width_p       = 15,
  parameter int count_width_p = 7
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     load_i,
  input  logic [width_p-1:0]       load_data_i,
  input  logic [count_width_p-1:0] load_count_i,
  input  logic                     shift_i,
  input  logic                     fill_i,
  output logic                     bit_o,
  output logic [count_width_p-1:0] count_o,
  output logic                     last_o
);

  logic [width_p-1:0]       data_reg;
  logic [width_p-1:0]       data_shifted;
  logic [count_width_p-1:0] count_reg;

  genvar gi;
  for (gi = 0; gi < width_p; gi++) begin : g_shift
    if (gi == width_p-1) begin : g_top
      assign data_shifted[gi] = fill_i;
    end else begin : g_body
      assign data_shifted[gi] = data_reg[gi+1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      data_reg  <= '0;
      count_reg <= '0;
    end else if (load_i) begin
      data_reg  <= load_data_i;
      count_reg <= load_count_i;
    end else if (shift_i) begin
      data_reg  <= data_shifted;
      count_reg <= count_reg - count_width_p'(1);
    end
  end

  assign bit_o   = data_reg[0];
  assign count_o = count_reg;
  assign last_o  = (count_reg == '0);

endmodule

// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag_serial_tx
//   Serialises one bsg_tag command per valid/ready handshake onto tag_data_o,
//   or emits the master-reset run of ones. Frame: start(1), len (LSB first),
//   data_not_reset, node_id (LSB first), len payload bits (LSB first),
//   followed by min_gap_p zeros.
//   Ports:
//     clk_i, reset_n_i : clock (also the external tag_clk), sync active-low reset
//     v_i / ready_and_o: command handshake; ready only while idle
//     master_reset_i   : send the master-reset sequence instead of a packet
//     node_id_i, data_not_reset_i, len_i, payload_i : packet fields
//     tag_data_o       : registered serial data
//     busy_o           : high whenever not idle
//     done_o           : one-cycle pulse on the last gap bit
module bsg_tag_serial_tx
  import bsg_tag_tx_pkg::*;
#(
  parameter int lg_els_p     = 6,
  parameter int lg_width_p   = 4,
  parameter int reset_ones_p = 64,
  parameter int min_gap_p    = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  output logic                         ready_and_o,
  input  logic                         master_reset_i,
  input  logic [lg_els_p-1:0]          node_id_i,
  input  logic                         data_not_reset_i,
  input  logic [lg_width_p-1:0]        len_i,
  input  logic [(1<<lg_width_p)-2:0]   payload_i,
  output logic                         tag_data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int payload_width_lp = (1 << lg_width_p) - 1;
  localparam int shift_width_lp   = max4(payload_width_lp, lg_els_p, lg_width_p, 2);
  localparam int count_max_lp     = max4(reset_ones_p, 1 << lg_width_p, lg_els_p, min_gap_p);
  localparam int count_width_lp   = $clog2(count_max_lp + 1);
  localparam logic gap_single_lp  = (min_gap_p == 1);

  `DECLARE_BSG_TAG_TX_CMD_S(lg_els_p, lg_width_p);

  bsg_tag_tx_cmd_s   cmd_reg;
  bsg_tag_tx_state_e state_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic              done_reg;

  logic                      handshake;
  logic                      sh_load;
  logic                      sh_shift;
  logic                      sh_fill;
  logic [shift_width_lp-1:0] sh_load_data;
  logic [count_width_lp-1:0] sh_load_count;
  logic                      sh_bit;
  logic [count_width_lp-1:0] sh_count;
  logic                      sh_last;

  assign handshake = v_i & ready_reg;

  // Shifter control: every field is loaded on entry to its state, so the
  // load contents are chosen by the state being left.
  always_comb begin
    sh_load       = (state_reg == e_idle) ? handshake : sh_last;
    sh_shift      = (state_reg != e_idle) && !sh_last;
    // ones are shifted in only while a reset command is draining its run
    sh_fill       = (state_reg == e_mrst) && cmd_reg.master_reset;
    sh_load_data  = '0;
    sh_load_count = '0;
    unique case (state_reg)
      e_idle: begin
        if (master_reset_i) begin
          sh_load_data  = '1;
          sh_load_count = count_width_lp'(reset_ones_p - 1);
        end else begin
          sh_load_data  = shift_width_lp'(1);
          sh_load_count = '0;
        end
      end
      e_start: begin
        sh_load_data  = shift_width_lp'(cmd_reg.len);
        sh_load_count = count_width_lp'(lg_width_p - 1);
      end
      e_len: begin
        sh_load_data  = shift_width_lp'(cmd_reg.data_not_reset);
        sh_load_count = '0;
      end
      e_dnr: begin
        sh_load_data  = shift_width_lp'(cmd_reg.node_id);
        sh_load_count = count_width_lp'(lg_els_p - 1);
      end
      e_node: begin
        if (cmd_reg.len != '0) begin
          sh_load_data  = shift_width_lp'(cmd_reg.payload);
          sh_load_count = count_width_lp'(cmd_reg.len) - count_width_lp'(1);
        end else begin
          sh_load_data  = '0;
          sh_load_count = count_width_lp'(min_gap_p - 1);
        end
      end
      e_mrst, e_payload: begin
        sh_load_data  = '0;
        sh_load_count = count_width_lp'(min_gap_p - 1);
      end
      e_gap: begin
        sh_load_data  = '0;
        sh_load_count = '0;
      end
      default: begin
        sh_load_data  = '0;
        sh_load_count = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg <= e_idle;
      cmd_reg   <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        e_idle: begin
          if (handshake) begin
            cmd_reg.master_reset   <= master_reset_i;
            cmd_reg.node_id        <= node_id_i;
            cmd_reg.data_not_reset <= data_not_reset_i;
            cmd_reg.len            <= len_i;
            cmd_reg.payload        <= payload_i;
            state_reg              <= master_reset_i ? e_mrst : e_start;
            ready_reg              <= 1'b0;
            busy_reg               <= 1'b1;
          end
        end
        e_mrst: begin
          if (sh_last) begin
            state_reg <= e_gap;
            done_reg  <= gap_single_lp;
          end
        end
        e_start:   if (sh_last) state_reg <= e_len;
        e_len:     if (sh_last) state_reg <= e_dnr;
        e_dnr:     if (sh_last) state_reg <= e_node;
        e_node: begin
          if (sh_last) begin
            if (cmd_reg.len == '0) begin
              state_reg <= e_gap;
              done_reg  <= gap_single_lp;
            end else begin
              state_reg <= e_payload;
            end
          end
        end
        e_payload: begin
          if (sh_last) begin
            state_reg <= e_gap;
            done_reg  <= gap_single_lp;
          end
        end
        e_gap: begin
          if (sh_last) begin
            state_reg <= e_idle;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            // the cycle after this one is the last gap bit
            done_reg <= (sh_count == count_width_lp'(1));
          end
        end
        default: state_reg <= e_idle;
      endcase
    end
  end

  bsg_tag_tx_shifter #(
    .width_p       (shift_width_lp),
    .count_width_p (count_width_lp)
  ) shifter (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .load_i       (sh_load),
    .load_data_i  (sh_load_data),
    .load_count_i (sh_load_count),
    .shift_i      (sh_shift),
    .fill_i       (sh_fill),
    .bit_o        (sh_bit),
    .count_o      (sh_count),
    .last_o       (sh_last)
  );

  assign tag_data_o  = sh_bit;
  assign ready_and_o = ready_reg;
  assign busy_o      = busy_reg;
  assign done_o      = done_reg;

endmodule
